// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial ALU: op codes used by the control
// decoder and the sequencer, plus the sequencer state encoding.
package bs_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLLI = 3'b101;
  localparam logic [2:0] OP_SRLI = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // The unused code 3'b111 behaves exactly like ADD.
  function automatic logic [2:0] normalize_op(input logic [2:0] op);
    return (op == 3'b111) ? OP_ADD : op;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_sequencer_bit_counter.sv
// IW-bit up-counter with synchronous clear, count enable and a terminal-count
// compare; shared by the PRE alignment and RUN bit phases.
module bit_counter #(
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [IW-1:0] tc_val_i,
  output logic [IW-1:0] count_o,
  output logic          tc_o
);

  logic [IW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + IW'(1);
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == tc_val_i);

endmodule

// File: rtl/serial_sequencer.sv
// Cycle-level sequencer for the bit-serial ALU: steps one LSB-first operation,
// producing shift/zero-fill strobes, the running carry and the C/Z flags.
module serial_sequencer
  import bs_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    alu_op,
  input  logic [IW-1:0] shamt,
  input  logic          carry_in,
  input  logic          res_bit,
  output logic          busy,
  output logic          done,
  output logic          opnd_shift_en,
  output logic          res_shift_en,
  output logic          res_zero,
  output logic          invert_b,
  output logic          carry_q,
  output logic [IW-1:0] bit_idx,
  output logic          flag_c,
  output logic          flag_z
);

  seq_state_e    state_q;
  logic [2:0]    op_q;
  logic [IW-1:0] shamt_q;

  logic [2:0]    start_op;
  logic          in_pre;
  logic          in_run;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_tc;
  logic [IW-1:0] cnt;
  logic [IW-1:0] cnt_tc_val;
  logic [IW:0]   srli_limit;

  assign start_op = normalize_op(alu_op);
  assign in_pre   = (state_q == ST_PRE);
  assign in_run   = (state_q == ST_RUN);

  // The counter is parked at zero in IDLE and recleared between PRE and RUN.
  assign cnt_clr    = (state_q == ST_IDLE) || (in_pre && cnt_tc);
  assign cnt_en     = in_pre || in_run;
  assign cnt_tc_val = in_pre ? (shamt_q - IW'(1)) : IW'(WIDTH - 1);

  bit_counter #(.IW(IW)) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (cnt_tc_val),
    .count_o  (cnt),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      shamt_q <= '0;
      carry_q <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= start_op;
            shamt_q <= shamt;
            carry_q <= (start_op == OP_SUB);
            flag_c  <= 1'b0;
            flag_z  <= 1'b1;
            state_q <= ((start_op == OP_SRLI) && (shamt != '0)) ? ST_PRE : ST_RUN;
          end
        end
        ST_PRE: begin
          if (cnt_tc) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (is_arith(op_q)) begin
            carry_q <= carry_in;
            if (cnt_tc) begin
              flag_c <= carry_in;
            end
          end
          if (res_bit) begin
            flag_z <= 1'b0;
          end
          if (cnt_tc) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // WIDTH fits in IW+1 bits, so the SRLI fill boundary never overflows.
  assign srli_limit = (IW + 1)'(WIDTH) - {1'b0, shamt_q};

  always_comb begin
    res_zero = 1'b0;
    if (in_run) begin
      if (op_q == OP_SLLI) begin
        res_zero = (cnt < shamt_q);
      end else if (op_q == OP_SRLI) begin
        res_zero = ({1'b0, cnt} >= srli_limit);
      end
    end
  end

  assign busy          = in_pre || in_run;
  assign done          = (state_q == ST_DONE);
  assign res_shift_en  = in_run;
  assign opnd_shift_en = in_pre || (in_run && !((op_q == OP_SLLI) && res_zero));
  assign invert_b      = in_run && (op_q == OP_SUB);
  assign bit_idx       = in_run ? cnt : '0;

endmodule

// File: tb/tb_serial_sequencer.sv
// Directed self-checking bench for serial_sequencer at WIDTH=8: each op is
// stepped cycle by cycle against hand-computed strobe and flag patterns.
module tb_serial_sequencer;

  localparam int WIDTH = 8;
  localparam int IW    = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    alu_op;
  logic [IW-1:0] shamt;
  logic          carry_in;
  logic          res_bit;
  logic          busy;
  logic          done;
  logic          opnd_shift_en;
  logic          res_shift_en;
  logic          res_zero;
  logic          invert_b;
  logic          carry_q;
  logic [IW-1:0] bit_idx;
  logic          flag_c;
  logic          flag_z;

  int passCount  = 0;
  int totalCount = 0;

  serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .alu_op        (alu_op),
    .shamt         (shamt),
    .carry_in      (carry_in),
    .res_bit       (res_bit),
    .busy          (busy),
    .done          (done),
    .opnd_shift_en (opnd_shift_en),
    .res_shift_en  (res_shift_en),
    .res_zero      (res_zero),
    .invert_b      (invert_b),
    .carry_q       (carry_q),
    .bit_idx       (bit_idx),
    .flag_c        (flag_c),
    .flag_z        (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount = totalCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] op, input logic [IW-1:0] sh);
    start  = st;
    alu_op = op;
    shamt  = sh;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [IW-1:0] sh,
                       input int preCycles, input logic [7:0] cinPat, input logic [7:0] resPat,
                       input logic [7:0] zeroMask, input logic [7:0] opndMask,
                       input logic [7:0] carryMask, input logic invB,
                       input logic expC, input logic expZ);
    applyStimulus(1'b1, op, sh);
    cyc();
    applyStimulus(1'b0, 3'b000, '0);
    for (int p = 0; p < preCycles; p++) begin
      checkOutput($sformatf("%s pre%0d busy", name, p), busy, 1);
      checkOutput($sformatf("%s pre%0d opnd_shift_en", name, p), opnd_shift_en, 1);
      checkOutput($sformatf("%s pre%0d res_shift_en", name, p), res_shift_en, 0);
      checkOutput($sformatf("%s pre%0d done", name, p), done, 0);
      cyc();
    end
    for (int i = 0; i < WIDTH; i++) begin
      checkOutput($sformatf("%s run%0d busy", name, i), busy, 1);
      checkOutput($sformatf("%s run%0d bit_idx", name, i), bit_idx, i);
      checkOutput($sformatf("%s run%0d res_shift_en", name, i), res_shift_en, 1);
      checkOutput($sformatf("%s run%0d res_zero", name, i), res_zero, zeroMask[i]);
      checkOutput($sformatf("%s run%0d opnd_shift_en", name, i), opnd_shift_en, opndMask[i]);
      checkOutput($sformatf("%s run%0d carry_q", name, i), carry_q, carryMask[i]);
      checkOutput($sformatf("%s run%0d invert_b", name, i), invert_b, invB);
      checkOutput($sformatf("%s run%0d done", name, i), done, 0);
      carry_in = cinPat[i];
      res_bit  = resPat[i];
      cyc();
    end
    carry_in = 1'b0;
    res_bit  = 1'b0;
    checkOutput({name, " done pulse"}, done, 1);
    checkOutput({name, " done busy"}, busy, 0);
    checkOutput({name, " done flag_c"}, flag_c, expC);
    checkOutput({name, " done flag_z"}, flag_z, expZ);
    checkOutput({name, " done res_shift_en"}, res_shift_en, 0);
    checkOutput({name, " done opnd_shift_en"}, opnd_shift_en, 0);
    checkOutput({name, " done invert_b"}, invert_b, 0);
    cyc();
    checkOutput({name, " idle done"}, done, 0);
    checkOutput({name, " idle flag_c held"}, flag_c, expC);
    checkOutput({name, " idle flag_z held"}, flag_z, expZ);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    alu_op   = 3'b000;
    shamt    = '0;
    carry_in = 1'b0;
    res_bit  = 1'b0;
    cyc();
    cyc();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset flag_z", flag_z, 1);
    checkOutput("reset flag_c", flag_c, 0);
    checkOutput("reset carry_q", carry_q, 0);
    checkOutput("reset bit_idx", bit_idx, 0);
    checkOutput("reset opnd_shift_en", opnd_shift_en, 0);
    checkOutput("reset res_shift_en", res_shift_en, 0);
    checkOutput("reset res_zero", res_zero, 0);
    checkOutput("reset invert_b", invert_b, 0);
    rst = 1'b0;
    cyc();
    checkOutput("idle busy", busy, 0);

    // name, op, shamt, pre, carry_in pattern, res_bit pattern, res_zero, opnd_shift_en, carry_q, invert_b, C, Z
    runOp("ADD",    3'b000, 3'd0, 0, 8'b1111_1000, 8'b0000_0100, 8'h00, 8'hFF, 8'b1111_0000, 1'b0, 1'b1, 1'b0);
    runOp("SUB",    3'b001, 3'd0, 0, 8'b0000_0000, 8'b0000_0000, 8'h00, 8'hFF, 8'b0000_0001, 1'b1, 1'b0, 1'b1);
    runOp("XOR",    3'b010, 3'd0, 0, 8'hFF,        8'h80,        8'h00, 8'hFF, 8'h00,        1'b0, 1'b0, 1'b0);
    runOp("SLLI3",  3'b101, 3'd3, 0, 8'hFF,        8'h00,        8'b0000_0111, 8'b1111_1000, 8'h00, 1'b0, 1'b0, 1'b1);
    runOp("SRLI2",  3'b110, 3'd2, 2, 8'h00,        8'h01,        8'b1100_0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    runOp("SRLI0",  3'b110, 3'd0, 0, 8'h00,        8'h00,        8'h00, 8'hFF, 8'h00,        1'b0, 1'b0, 1'b1);
    runOp("OP111",  3'b111, 3'd5, 0, 8'h80,        8'h00,        8'h00, 8'hFF, 8'h00,        1'b0, 1'b1, 1'b1);

    // A start re-pulsed mid-RUN must neither restart nor queue a second op.
    applyStimulus(1'b1, 3'b000, '0);
    cyc();
    for (int i = 0; i < WIDTH; i++) begin
      if (i == 4) applyStimulus(1'b1, 3'b001, '0);
      else applyStimulus(1'b0, 3'b000, '0);
      carry_in = (i == 7);
      checkOutput($sformatf("repulse run%0d done", i), done, 0);
      checkOutput($sformatf("repulse run%0d invert_b", i), invert_b, 0);
      cyc();
    end
    carry_in = 1'b0;
    checkOutput("repulse done pulse", done, 1);
    checkOutput("repulse flag_c", flag_c, 1);
    cyc();
    checkOutput("repulse idle done", done, 0);
    checkOutput("repulse idle busy", busy, 0);
    cyc();
    checkOutput("repulse no extra busy", busy, 0);
    checkOutput("repulse no extra done", done, 0);

    // Reset in the middle of RUN discards the partial operation at once.
    applyStimulus(1'b1, 3'b000, '0);
    cyc();
    applyStimulus(1'b0, 3'b000, '0);
    carry_in = 1'b1;
    res_bit  = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    checkOutput("midrst pre bit_idx", bit_idx, 5);
    checkOutput("midrst pre carry_q", carry_q, 1);
    checkOutput("midrst pre flag_z", flag_z, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst flag_z", flag_z, 1);
    checkOutput("midrst flag_c", flag_c, 0);
    checkOutput("midrst carry_q", carry_q, 0);
    checkOutput("midrst bit_idx", bit_idx, 0);
    checkOutput("midrst res_shift_en", res_shift_en, 0);
    checkOutput("midrst opnd_shift_en", opnd_shift_en, 0);
    cyc();
    rst      = 1'b0;
    carry_in = 1'b0;
    res_bit  = 1'b0;
    cyc();
    checkOutput("postrst busy", busy, 0);
    checkOutput("postrst done", done, 0);

    runOp("ADD2",   3'b000, 3'd0, 0, 8'b1000_0001, 8'b0001_0000, 8'h00, 8'hFF, 8'b0000_0010, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
